// File: rtl/jtag_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// jtag_uart_tx_sched
//
// Round-robin scheduler that lets NUM_REQ byte producers share one JTAG UART
// Avalon-MM slave. A byte is accepted from one producer at a time over a
// valid/ready handshake. The scheduler then polls the control register for
// write space (WSPACE) as needed and writes the byte to the data register,
// honouring waitrequest on every access.
//
// Write-space credit: the WSPACE value from the last successful poll is kept
// as a credit and spent one byte at a time. Only the host drains the UART
// FIFO, so real space can only grow between polls. Writing while credit != 0
// therefore never overflows the FIFO and needs no extra poll.
//
// Ports
//   i_clk            system clock
//   i_reset          asynchronous, active-high reset
//   i_req_valid      per-requester byte valid
//   i_req_data       byte of requester i at [8i+7:8i]
//   o_req_ready      one-hot, one-cycle accept pulse (transfer on valid&ready)
//   o_av_chipselect  Avalon chip select
//   o_av_address     0 = data register, 1 = control register
//   o_av_read_n      active-low read strobe
//   o_av_write_n     active-low write strobe
//   o_av_writedata   {24'b0, byte}
//   i_av_readdata    slave read data, WSPACE in [31:16]
//   i_av_waitrequest slave stall
//   o_busy           high whenever the scheduler is not idle
//   o_dropped        one-cycle pulse when a byte is discarded on poll timeout
// ---------------------------------------------------------------------------
module jtag_uart_tx_sched #(
    parameter int NUM_REQ   = 2,     // number of requesters (1..8)
    parameter int POLL_GAP  = 16,    // idle cycles between zero-space polls (>=1)
    parameter int MAX_POLLS = 1024   // zero-space polls before drop, 0 = never
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_av_chipselect,
    output logic                   o_av_address,
    output logic                   o_av_read_n,
    output logic                   o_av_write_n,
    output logic [31:0]            o_av_writedata,
    input  logic [31:0]            i_av_readdata,
    input  logic                   i_av_waitrequest,
    output logic                   o_busy,
    output logic                   o_dropped
);

    localparam int GW = (NUM_REQ > 1)   ? $clog2(NUM_REQ)       : 1;
    localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS + 1) : 1;
    localparam int CW = (POLL_GAP > 1)  ? $clog2(POLL_GAP)      : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_CTRL = 2'd1,
        S_BACKOFF = 2'd2,
        S_WR_DATA = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [GW-1:0]       r_rr_ptr;
    logic [GW-1:0]       r_grant;
    logic [7:0]          r_byte;
    logic [15:0]         r_credit;
    logic [PW-1:0]       r_poll_cnt;
    logic [CW-1:0]       r_gap_cnt;

    logic [NUM_REQ-1:0]  r_req_ready;
    logic                r_av_chipselect;
    logic                r_av_address;
    logic                r_av_read_n;
    logic                r_av_write_n;
    logic [31:0]         r_av_writedata;
    logic                r_busy;
    logic                r_dropped;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                w_found;
    logic [GW-1:0]       w_sel;
    logic [7:0]          w_sel_byte;
    logic [GW-1:0]       w_next_ptr;
    logic [15:0]         w_wspace;
    logic [15:0]         w_credit_dec;
    logic [PW-1:0]       w_poll_inc;
    logic                w_timeout;
    logic                w_unused_ok;

    // Requester index 'off' places after 'base', wrapping modulo NUM_REQ.
    function automatic logic [GW-1:0] f_rot(input logic [GW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return GW'(s);
    endfunction

    // One-hot vector with bit 'idx' set.
    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [GW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_wspace     = i_av_readdata[31:16];
    assign w_credit_dec = (r_credit != 16'd0) ? (r_credit - 16'd1) : 16'd0;
    assign w_poll_inc   = r_poll_cnt + PW'(1);
    assign w_timeout    = (MAX_POLLS != 0) && (w_poll_inc == PW'(MAX_POLLS));
    assign w_next_ptr   = (r_grant == GW'(NUM_REQ - 1)) ? GW'(0) : (r_grant + GW'(1));
    // Low half of readdata carries no information for this block.
    assign w_unused_ok  = ^i_av_readdata[15:0];

    // Round-robin search from r_rr_ptr; walked from the far end so the
    // nearest valid requester is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[f_rot(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = f_rot(r_rr_ptr, k);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Select the byte of the winning requester.
    always_comb begin
        w_sel_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel == GW'(k)) begin
                w_sel_byte = i_req_data[8*k +: 8];
            end else begin
                w_sel_byte = w_sel_byte;
            end
        end
    end

    // Scheduler FSM with registered Avalon strobes and handshake outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= '0;
            r_grant         <= '0;
            r_byte          <= 8'h00;
            r_credit        <= 16'd0;
            r_poll_cnt      <= '0;
            r_gap_cnt       <= '0;
            r_req_ready     <= '0;
            r_av_chipselect <= 1'b0;
            r_av_address    <= 1'b0;
            r_av_read_n     <= 1'b1;
            r_av_write_n    <= 1'b1;
            r_av_writedata  <= 32'h0000_0000;
            r_busy          <= 1'b0;
            r_dropped       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_req_ready <= '0;
            r_dropped   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant         <= w_sel;
                        r_byte          <= w_sel_byte;
                        r_req_ready     <= f_onehot(w_sel);
                        r_av_chipselect <= 1'b1;
                        r_busy          <= 1'b1;
                        if (r_credit != 16'd0) begin
                            // Known space: skip the poll and write at once.
                            r_state        <= S_WR_DATA;
                            r_av_address   <= 1'b0;
                            r_av_write_n   <= 1'b0;
                            r_av_writedata <= {24'h00_0000, w_sel_byte};
                        end else begin
                            r_state      <= S_RD_CTRL;
                            r_av_address <= 1'b1;
                            r_av_read_n  <= 1'b0;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                S_RD_CTRL: begin
                    if (!i_av_waitrequest) begin
                        r_credit    <= w_wspace;
                        r_av_read_n <= 1'b1;
                        if (w_wspace != 16'd0) begin
                            // Chip select stays high straight into the write.
                            r_state        <= S_WR_DATA;
                            r_av_address   <= 1'b0;
                            r_av_write_n   <= 1'b0;
                            r_av_writedata <= {24'h00_0000, r_byte};
                        end else if (w_timeout) begin
                            r_state         <= S_IDLE;
                            r_av_chipselect <= 1'b0;
                            r_av_address    <= 1'b0;
                            r_busy          <= 1'b0;
                            r_dropped       <= 1'b1;
                            r_poll_cnt      <= '0;
                            r_rr_ptr        <= w_next_ptr;
                        end else begin
                            r_state         <= S_BACKOFF;
                            r_av_chipselect <= 1'b0;
                            r_av_address    <= 1'b0;
                            r_poll_cnt      <= w_poll_inc;
                            r_gap_cnt       <= '0;
                        end
                    end else begin
                        r_state <= S_RD_CTRL;
                    end
                end

                S_BACKOFF: begin
                    // Exactly POLL_GAP idle cycles before the next poll.
                    if (r_gap_cnt == CW'(POLL_GAP - 1)) begin
                        r_state         <= S_RD_CTRL;
                        r_av_chipselect <= 1'b1;
                        r_av_address    <= 1'b1;
                        r_av_read_n     <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + CW'(1);
                    end
                end

                S_WR_DATA: begin
                    if (!i_av_waitrequest) begin
                        r_state         <= S_IDLE;
                        r_av_chipselect <= 1'b0;
                        r_av_write_n    <= 1'b1;
                        r_busy          <= 1'b0;
                        r_credit        <= w_credit_dec;
                        r_poll_cnt      <= '0;
                        r_rr_ptr        <= w_next_ptr;
                    end else begin
                        r_state <= S_WR_DATA;
                    end
                end

                default: begin
                    r_state         <= S_IDLE;
                    r_av_chipselect <= 1'b0;
                    r_av_address    <= 1'b0;
                    r_av_read_n     <= 1'b1;
                    r_av_write_n    <= 1'b1;
                    r_busy          <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready     = r_req_ready;
    assign o_av_chipselect = r_av_chipselect;
    assign o_av_address    = r_av_address;
    assign o_av_read_n     = r_av_read_n;
    assign o_av_write_n    = r_av_write_n;
    assign o_av_writedata  = r_av_writedata;
    assign o_busy          = r_busy;
    assign o_dropped       = r_dropped;

endmodule
